// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared fetch pipeline types and reset default
package fetch_pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

    typedef struct packed {
        logic        taken;
        logic        slot;
        logic [31:0] target;
    } bpu_predict_t;

    // pc is the fetch-group address of the branch; slot selects the word inside the group
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        slot;
        logic        taken;
        logic [31:0] target;
    } bpu_correct_t;

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer, combinational reads, one sync write
module fetch_btb
    import fetch_pc_gen_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = 29 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [29:0]      rd_target_o,
    output logic             rd_slot_o,
    input  logic [IDX_W-1:0] chk_idx_i,
    output logic             chk_valid_o,
    output logic [TAG_W-1:0] chk_tag_o,
    output logic [29:0]      chk_target_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_valid_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [29:0]      wr_target_i,
    input  logic             wr_slot_i
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [29:0]      target_q [DEPTH];
    logic             slot_q   [DEPTH];

    // Only the valid bits need reset; payload is ignored while invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            slot_q[wr_idx_i]   <= wr_slot_i;
        end
    end

    assign rd_valid_o   = valid_q[rd_idx_i];
    assign rd_tag_o     = tag_q[rd_idx_i];
    assign rd_target_o  = target_q[rd_idx_i];
    assign rd_slot_o    = slot_q[rd_idx_i];

    assign chk_valid_o  = valid_q[chk_idx_i];
    assign chk_tag_o    = tag_q[chk_idx_i];
    assign chk_target_o = target_q[chk_idx_i];

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch pc generator with optional BTB (macro FETCH_PC_GEN_BTB_EN)
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BTB_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rst_jmp_i,
    input  logic [31:0]      rst_target_i,
    input  logic             f_stall_i,
    output logic [1:0][31:0] pc_o,
    output logic [1:0]       valid_o,
    output bpu_predict_t     predict_o,
    input  bpu_correct_t     correct_i
);

    logic [31:0] pc_q, pc_d;
    logic        run_q;
    logic [31:0] seq_pc;
    logic        pred_taken;
    logic        pred_slot;
    logic [31:0] pred_target;

    assign seq_pc = {pc_q[31:3] + 29'd1, 3'b000};

`ifdef FETCH_PC_GEN_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = 29 - IDX_W;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_valid, up_valid;
    logic [29:0]      lk_target, up_target;
    logic             lk_slot;
    logic             lk_hit;
    logic             up_tag_hit;
    logic             up_we, up_wvalid;

    assign lk_idx = pc_q[3+IDX_W-1:3];
    assign up_idx = correct_i.pc[3+IDX_W-1:3];

    fetch_btb #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx_i     (lk_idx),
        .rd_valid_o   (lk_valid),
        .rd_tag_o     (lk_tag),
        .rd_target_o  (lk_target),
        .rd_slot_o    (lk_slot),
        .chk_idx_i    (up_idx),
        .chk_valid_o  (up_valid),
        .chk_tag_o    (up_tag),
        .chk_target_o (up_target),
        .wr_en_i      (up_we),
        .wr_idx_i     (up_idx),
        .wr_valid_i   (up_wvalid),
        .wr_tag_i     (correct_i.pc[31:3+IDX_W]),
        .wr_target_i  (correct_i.target[31:2]),
        .wr_slot_i    (correct_i.slot)
    );

    // An entry for slot 0 cannot apply when fetch enters the group at slot 1
    assign lk_hit      = lk_valid && (lk_tag == pc_q[31:3+IDX_W]) && (lk_slot >= pc_q[2]);
    assign pred_taken  = lk_hit;
    assign pred_slot   = lk_hit ? lk_slot : 1'b0;
    assign pred_target = lk_hit ? {lk_target, 2'b00} : seq_pc;

    assign up_tag_hit = up_valid && (up_tag == correct_i.pc[31:3+IDX_W]);

    always_comb begin
        up_we     = 1'b0;
        up_wvalid = 1'b0;
        if (correct_i.valid) begin
            if (correct_i.taken && (!up_tag_hit || (up_target != correct_i.target[31:2]))) begin
                up_we     = 1'b1;
                up_wvalid = 1'b1;
            end else if (!correct_i.taken && up_tag_hit) begin
                up_we     = 1'b1;
                up_wvalid = 1'b0;
            end
        end
    end

    logic unused_correct_bits;
    assign unused_correct_bits = ^{correct_i.pc[2:0], correct_i.target[1:0]};
`else
    assign pred_taken  = 1'b0;
    assign pred_slot   = 1'b0;
    assign pred_target = seq_pc;

    logic unused_correct_bits;
    assign unused_correct_bits = ^{correct_i};
`endif

    logic unused_target_bits;
    assign unused_target_bits = ^{rst_target_i[1:0]};

    // Redirect beats stall; before the first post-reset edge the pc is held like a stall
    always_comb begin
        pc_d = pc_q;
        if (rst_jmp_i) begin
            pc_d = {rst_target_i[31:2], 2'b00};
        end else if (f_stall_i || !run_q) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            run_q <= 1'b1;
        end
    end

    assign pc_o[0]          = pc_q;
    assign pc_o[1]          = {pc_q[31:3], 3'b100};
    assign valid_o[0]       = run_q & ~pc_q[2];
    assign valid_o[1]       = run_q & ~(pred_taken & ~pred_slot);
    assign predict_o.taken  = pred_taken;
    assign predict_o.slot   = pred_slot;
    assign predict_o.target = pred_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen
module tb_fetch_pc_gen;
    import fetch_pc_gen_pkg::*;

`ifdef FETCH_PC_GEN_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    typedef struct {
        logic        in_rst;
        logic [31:0] pc0;
        logic [1:0]  vld;
        logic        taken;
        logic        slot;
        logic [31:0] tgt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rst_jmp_i = 1'b0;
    logic [31:0]      rst_target_i = 32'h0;
    logic             f_stall_i = 1'b0;
    logic [1:0][31:0] pc_o;
    logic [1:0]       valid_o;
    bpu_predict_t     predict_o;
    bpu_correct_t     correct_i;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rst_jmp_i    (rst_jmp_i),
        .rst_target_i (rst_target_i),
        .f_stall_i    (f_stall_i),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .predict_o    (predict_o),
        .correct_i    (correct_i)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain: %0d groups never presented, required 0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (!rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].in_rst) begin
                e = exp_q.pop_front();
                cmp("rst_pc0", pc_o[0], e.pc0);
                cmp("rst_valid", {30'd0, valid_o}, {30'd0, e.vld});
                cmp("rst_taken", {31'd0, predict_o.taken}, {31'd0, e.taken});
            end
        end else if (valid_o != 2'b00) begin
            if (exp_q.size() == 0 || exp_q[0].in_rst) begin
                checks++;
                errors++;
                $display("FAIL unexpected_group: pc %h valid %b, required no group", pc_o[0], valid_o);
            end else begin
                e = exp_q.pop_front();
                cmp("pc0", pc_o[0], e.pc0);
                cmp("pc1", pc_o[1], {e.pc0[31:3], 3'b100});
                cmp("valid", {30'd0, valid_o}, {30'd0, e.vld});
                cmp("taken", {31'd0, predict_o.taken}, {31'd0, e.taken});
                if (e.taken) begin
                    cmp("pred_slot", {31'd0, predict_o.slot}, {31'd0, e.slot});
                    cmp("pred_target", predict_o.target, e.tgt);
                end
            end
        end
    end

    task automatic cyc(input logic jmp, input logic [31:0] tgt, input logic stall,
                       input logic cv, input logic [31:0] cpc, input logic cslot,
                       input logic ctk, input logic [31:0] ctg,
                       input logic [31:0] e_pc, input logic [1:0] e_vld,
                       input logic e_tk, input logic e_slot, input logic [31:0] e_tgt);
        rst_jmp_i        = jmp;
        rst_target_i     = tgt;
        f_stall_i        = stall;
        correct_i.valid  = cv;
        correct_i.pc     = cpc;
        correct_i.slot   = cslot;
        correct_i.taken  = ctk;
        correct_i.target = ctg;
        exp_q.push_back('{1'b0, e_pc, e_vld, e_tk, e_slot, e_tgt});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset();
        exp_q.push_back('{1'b1, RESET_PC_DEFAULT, 2'b00, 1'b0, 1'b0, 32'h0});
    endtask

    initial begin
        correct_i = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential fetch after reset release
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000000, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000008, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000010, 2'b11, 0, 0, 32'h0);
        // Redirect under stall, then hold while stalled
        cyc(1, 32'h1c000104, 1, 0, 32'h0, 0, 0, 32'h0, 32'h1c000018, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h1c000104, 2'b10, 0, 0, 32'h0);
        cyc(0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h1c000104, 2'b10, 0, 0, 32'h0);
        // Train taken branch in slot 1 of group 1c000020
        cyc(0, 32'h0, 0, 1, 32'h1c000020, 1, 1, 32'h1c000400, 32'h1c000104, 2'b10, 0, 0, 32'h0);
        cyc(1, 32'h1c000020, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000108, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000020, 2'b11, BTB, 1, 32'h1c000400);
        // Not-taken resolution clears the entry
        cyc(1, 32'h1c000020, 0, 1, 32'h1c000024, 1, 0, 32'h0,
            BTB ? 32'h1c000400 : 32'h1c000028, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000020, 2'b11, 0, 0, 32'h0);
        // Train slot 0 entry, then enter the group at slot 1
        cyc(1, 32'h1c000020, 0, 1, 32'h1c000020, 0, 1, 32'h1c000400, 32'h1c000028, 2'b11, 0, 0, 32'h0);
        cyc(1, 32'h1c000024, 0, 0, 32'h0, 0, 0, 32'h0,
            32'h1c000020, BTB ? 2'b01 : 2'b11, BTB, 0, 32'h1c000400);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000024, 2'b10, 0, 0, 32'h0);
        // Address wrap
        cyc(1, 32'hfffffff8, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000028, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'hfffffff8, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h00000000, 2'b11, 0, 0, 32'h0);

        // Reset mid-operation with a redirect and an update pending
        rst_n            = 1'b0;
        rst_jmp_i        = 1'b1;
        rst_target_i     = 32'h1c000300;
        correct_i.valid  = 1'b1;
        correct_i.pc     = 32'h1c000100;
        correct_i.slot   = 1'b0;
        correct_i.taken  = 1'b1;
        correct_i.target = 32'h1c000800;
        expect_reset();
        @(posedge clk);
        #1;
        rst_jmp_i = 1'b0;
        correct_i = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 32'h1c000020, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000000, 2'b11, 0, 0, 32'h0);
        cyc(1, 32'h1c000100, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000020, 2'b11, 0, 0, 32'h0);
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h1c000100, 2'b11, 0, 0, 32'h0);

        rst_n = 1'b0;
        done  = 1'b1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation timed out, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
